// File: rtl/serial_word_rx.sv
// Serial-to-word receiver: assembles MSB-first framed bits into WIDTH-bit
// words and buffers them in a DEPTH-entry FIFO drained by valid/ready.
module serial_word_rx #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err,
    output logic [7:0]       err_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [OW-1:0]    occ;

    logic [WIDTH-1:0] shifted;
    logic             done;
    logic             ferr;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // sr holds the bits received so far; the last bit completes the word
    assign shifted = {sr, bit_in};
    assign done    = (state == SHIFT) && bit_valid && !frame_start
                     && (count == CW'(WIDTH - 1));
    assign ferr    = (state == SHIFT) && bit_valid && frame_start;
    assign full    = (occ == OW'(DEPTH));
    assign pop     = word_valid && word_ready;
    assign push    = done && (!full || pop);
    assign drop    = done && full && !pop;

    assign word_valid = (occ != '0);
    assign word_out   = word_valid ? mem[rd_ptr] : '0;
    assign busy       = (state == SHIFT);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            overflow  <= drop;
            frame_err <= ferr;
            if ((drop || ferr) && err_count != 8'hff)
                err_count <= err_count + 8'd1;
            if (bit_valid) begin
                unique case (state)
                    IDLE: begin
                        if (frame_start) begin
                            sr    <= (WIDTH-1)'(bit_in);
                            count <= CW'(1);
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (frame_start) begin
                            sr    <= (WIDTH-1)'(bit_in);
                            count <= CW'(1);
                        end else if (done) begin
                            count <= '0;
                            state <= IDLE;
                        end else begin
                            sr    <= shifted[WIDTH-2:0];
                            count <= count + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                occ <= occ + 1'b1;
            else if (pop && !push)
                occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= shifted;
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: directed scenarios plus random traffic
// compared every cycle against a bit-list / word-queue reference.
module tb_serial_word_rx;

    localparam int WIDTH = 3;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready = 1'b0;
    logic             busy;
    logic             overflow;
    logic             frame_err;
    logic [7:0]       err_count;

    int n_checks = 0;
    int n_errs = 0;

    // reference state
    logic [WIDTH-1:0] q[$];
    bit               m_busy;
    int               m_nbits;
    int               m_acc;
    int               m_errs;
    bit               m_ovf;
    bit               m_ferr;
    logic [WIDTH-1:0] seen[$];

    serial_word_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .frame_start(frame_start),
        .word_out(word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .busy(busy),
        .overflow(overflow),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit bv, input bit fs, input bit b,
                              input bit rdy);
        bit pop;
        bit completed;
        completed = 0;
        m_ovf = 0;
        m_ferr = 0;
        if (!rst_n) begin
            q.delete();
            m_busy = 0;
            m_nbits = 0;
            m_acc = 0;
            m_errs = 0;
            return;
        end
        pop = (q.size() != 0) && rdy;
        if (bv) begin
            if (fs) begin
                if (m_busy) m_ferr = 1;
                m_busy = 1;
                m_acc = int'(b);
                m_nbits = 1;
            end else if (m_busy) begin
                m_acc = m_acc * 2 + int'(b);
                m_nbits++;
                if (m_nbits == WIDTH) begin
                    m_busy = 0;
                    completed = 1;
                end
            end
        end
        if (pop) begin
            seen.push_back(q[0]);
            void'(q.pop_front());
        end
        if (completed) begin
            if (q.size() < DEPTH) q.push_back(WIDTH'(m_acc));
            else m_ovf = 1;
        end
        m_errs = m_errs + int'(m_ovf) + int'(m_ferr);
        if (m_errs > 255) m_errs = 255;
    endtask

    task automatic check_outputs();
        logic [WIDTH-1:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        chk("word_valid", 32'(word_valid), 32'(q.size() != 0));
        chk("word_out", 32'(word_out), 32'(head));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("err_count", 32'(err_count), 32'(m_errs));
    endtask

    task automatic cycle(input bit bv, input bit fs, input bit b,
                         input bit rdy);
        bit_valid = bv;
        frame_start = fs;
        bit_in = b;
        word_ready = rdy;
        @(posedge clk);
        model_edge(bv, fs, b, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(0, 0, 0, 0);
        rst_n = 1'b1;
        seen.delete();
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input bit rdy);
        for (int i = WIDTH - 1; i >= 0; i--)
            cycle(1, i == WIDTH - 1, w[i], rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 0, rdy);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_word_valid", 32'(word_valid), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);

        // basic word
        send_frame(3'b100, 1);
        idle(3, 1);
        chk("basic_n", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) chk("basic_word", 32'(seen[0]), 32'(3'b100));

        // back-to-back
        do_reset();
        send_frame(3'b011, 1);
        send_frame(3'b110, 1);
        idle(3, 1);
        chk("b2b_n", 32'(seen.size()), 32'd2);
        if (seen.size() > 1) begin
            chk("b2b_w0", 32'(seen[0]), 32'(3'b011));
            chk("b2b_w1", 32'(seen[1]), 32'(3'b110));
        end
        chk("b2b_errs", 32'(err_count), 32'd0);

        // overflow
        do_reset();
        send_frame(3'b001, 0);
        send_frame(3'b010, 0);
        send_frame(3'b111, 0);
        idle(2, 0);
        chk("ovf_errs", 32'(err_count), 32'd1);
        chk("ovf_head", 32'(word_out), 32'(3'b001));
        idle(4, 1);
        chk("ovf_n", 32'(seen.size()), 32'd2);
        if (seen.size() > 1) begin
            chk("ovf_w0", 32'(seen[0]), 32'(3'b001));
            chk("ovf_w1", 32'(seen[1]), 32'(3'b010));
        end
        chk("ovf_empty", 32'(word_valid), 32'h0);

        // full FIFO with simultaneous pop on the completing edge
        do_reset();
        send_frame(3'b101, 0);
        send_frame(3'b011, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 1);
        idle(4, 1);
        chk("fpop_errs", 32'(err_count), 32'd0);
        chk("fpop_n", 32'(seen.size()), 32'd3);
        if (seen.size() > 2) begin
            chk("fpop_w0", 32'(seen[0]), 32'(3'b101));
            chk("fpop_w1", 32'(seen[1]), 32'(3'b011));
            chk("fpop_w2", 32'(seen[2]), 32'(3'b110));
        end

        // framing error
        do_reset();
        cycle(1, 1, 1, 1);
        cycle(1, 0, 0, 1);
        cycle(1, 1, 1, 1);
        cycle(1, 0, 1, 1);
        cycle(1, 0, 1, 1);
        idle(3, 1);
        chk("ferr_errs", 32'(err_count), 32'd1);
        chk("ferr_n", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) chk("ferr_word", 32'(seen[0]), 32'(3'b111));

        // reset mid-frame with a buffered word
        do_reset();
        send_frame(3'b110, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 1, 0);
        do_reset();
        chk("mrst_valid", 32'(word_valid), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        send_frame(3'b101, 1);
        idle(2, 1);
        chk("mrst_n", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) chk("mrst_word", 32'(seen[0]), 32'(3'b101));

        // err_count saturation via repeated frame errors
        do_reset();
        for (int i = 0; i < 300; i++)
            cycle(1, 1, 1, 0);
        chk("sat_errs", 32'(err_count), 32'd255);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0,
                      $urandom_range(0, 4) == 0,
                      1'($urandom),
                      $urandom_range(0, 2) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial receiver that rebuilds WIDTH-bit words from a framed, one-bit-per-beat stream. It is the receiving end of the bit-reversing word path: the bit order is undone on assembly, so the first received bit lands in the word MSB. Completed words are buffered in a small output FIFO and drained through a valid/ready handshake. The block sits between a serial link and downstream word-wide logic such as the bit-swap stage.

## Interface
- WIDTH, 3, bits per word; must be ≥ 2.
- DEPTH, 2, output FIFO entries; must be ≥ 1.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- bit_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  bit_in carries a bit this cycle.
- frame_start  input  1  marks the first bit of a word; ignored unless bit_valid=1.
- word_out  output  WIDTH  word at the FIFO head; holds 0 when the FIFO is empty.
- word_valid  output  1  FIFO is not empty.
- word_ready  input  1  consumer accepts word_out this cycle.
- busy  output  1  a frame is partially received (state SHIFT).
- overflow  output  1  one-cycle pulse: a completed word was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse: frame_start arrived mid-frame and the partial word was discarded.
- err_count  output  8  saturating count of overflow plus frame_err events.

## Operation
- Reset (rst_n=0 at an edge) clears all state. All outputs read 0 after reset: word_out, word_valid, busy, overflow, frame_err and err_count. The FIFO is emptied and the FSM goes to IDLE.
- **FSM states:** IDLE and SHIFT.
  - **IDLE:**
    - bit_valid & frame_start: load the shift register with bit_in, set count=1, go to SHIFT.
    - bit_valid & !frame_start: discard the bit (stray bit). No error is flagged.
  - **SHIFT:**
    - bit_valid & !frame_start: shift left, sr <= {sr[WIDTH-2:0], bit_in}, and increment count.
    - bit_valid & frame_start: pulse frame_err. The new bit becomes bit 1 of a new frame: sr <= bit_in, count=1. Stay in SHIFT.
    - When the shift brings count to WIDTH, the assembled word {sr[WIDTH-2:0], bit_in} is offered to the FIFO and the FSM returns to IDLE.
- **Bit mapping:** the first received bit goes to word_out[WIDTH-1] and the last to word_out[0].
- **FIFO:** DEPTH entries with read and write pointers that wrap modulo DEPTH. The occupancy counter runs 0..DEPTH.
  - Push happens when a word completes and the FIFO is not full, or when it is full but a pop occurs in the same cycle.
  - If a word completes while the FIFO is full and no pop occurs, the word is dropped and overflow pulses.
  - Pop happens when word_valid & word_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
- **err_count:** increments by 1 for each overflow or frame_err pulse and saturates at 255. overflow and frame_err never pulse in the same cycle.
- **busy:** equals (state == SHIFT).

## Timing
- A word is accepted into the FIFO at the edge that samples its last bit. word_valid rises at that same edge if the FIFO was empty, so there is 1 cycle of latency from the last bit_valid cycle to word_valid.
- Back-to-back frames with no idle cycles are supported. A frame_start on the cycle right after the last bit is a clean start in IDLE, not an error.
- word_out and word_valid are registered FIFO outputs. They are stable while word_valid=1 and word_ready=0.
- A pop updates word_out and word_valid at the next edge. There is no combinational path from word_ready to word_valid.
- overflow and frame_err are high for exactly one cycle, the cycle after the edge where the event is decided.
- Reset asserted mid-frame or with the FIFO full takes effect at the next edge. No partial word survives.

## Test plan
- **Basic word** (WIDTH=3): send bits 1,0,0 with frame_start on the first bit and word_ready=1. Expect word_out=3'b100 with word_valid=1 for one cycle, starting 1 cycle after the third bit. busy is high for 2 cycles.
- **Back-to-back frames:** send 0,1,1 then 1,1,0 with no gap and word_ready=1. Expect the words 3'b011 then 3'b110 in order, frame_err=0, err_count=0.
- **Overflow** (DEPTH=2, word_ready=0): send 3 frames 001, 010, 111. Expect word_valid=1 with head 3'b001, and overflow pulsing once when the third word completes, so err_count=1. Raise word_ready: expect 001 then 010, then word_valid=0.
- **Full FIFO with simultaneous pop:** fill 2 words, then complete a third while word_ready=1 on that cycle. Expect no overflow and the output order 1st, 2nd, 3rd.
- **Framing error:** send 1,0 then frame_start with 1, then 1,1. Expect a frame_err pulse, the word 3'b111, and err_count=1.
- **Reset mid-frame:** after 2 bits plus one buffered word, assert rst_n=0 for 1 cycle. Expect all outputs 0 and then a clean receive of 3'b101.
